// File: rtl/ni_slave_core.sv
// Target-side NoC network interface: VC0 request packets -> one Wishbone master cycle -> VC1 response packet.
// Optional NI_SLV_TIMEOUT_EN: a Wishbone cycle without ack for WB_TIMEOUT cycles is abandoned and answered with 32'hDEAD_BEEF.
module ni_slave_core #(
  parameter int MY_X       = 0,
  parameter int MY_Y       = 0,
  parameter int RX_DEPTH   = 3,
  parameter int TX_CREDITS = 3,
  parameter int WB_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:35] channel_in,
  output logic [0:1]  flow_ctrl_out,
  output logic [0:35] channel_out,
  input  logic [0:1]  flow_ctrl_in,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);
  localparam logic [1:0] LX = 2'(MY_X);
  localparam logic [1:0] LY = 2'(MY_Y);
  localparam int PW  = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int FCW = $clog2(RX_DEPTH + 1);
  localparam int CRW = $clog2(TX_CREDITS + 1);

  typedef enum logic [2:0] {S_IDLE, S_DROP, S_GET_DATA, S_WB, S_RSP_HEAD, S_RSP_DATA} state_t;

  state_t           r_state, w_state_n;
  logic [33:0]      r_mem [RX_DEPTH];
  logic [PW-1:0]    r_wp, r_rp;
  logic [FCW-1:0]   r_cnt;
  logic             r_ovf;
  logic [CRW-1:0]   r_credit;
  logic [3:0]       r_src;
  logic [18:0]      r_cmd;
  logic [31:0]      r_wdat, r_rdat;
  logic [34:0]      r_last;
  logic             r_fc0, r_fc1;

  logic             w_empty, w_full, w_push_req, w_push, w_pop;
  logic             w_f_head, w_f_tail, w_hit, w_cr_ok, w_tmo;
  logic [31:0]      w_f_pay, w_rsp_hdr, w_op;
  logic [2:0]       w_port;
  logic             w_send, w_oh, w_ot;
  logic             w_unused;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(RX_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // RX FIFO; a push is accepted when full only if the head leaves the same cycle
  assign w_empty    = (r_cnt == '0);
  assign w_full     = (r_cnt == FCW'(RX_DEPTH));
  assign w_push_req = channel_in[0] & ~channel_in[1];
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign {w_f_head, w_f_tail, w_f_pay} = r_mem[r_rp];
  assign w_hit      = (w_f_pay[28:27] == LX) && (w_f_pay[26:25] == LY);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0; r_rp <= '0; r_cnt <= '0; r_ovf <= 1'b0;
    end else begin
      if (w_push) r_wp <= f_inc(r_wp);
      if (w_pop)  r_rp <= f_inc(r_rp);
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
      if (w_push_req && !w_push) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= {channel_in[2], channel_in[3], channel_in[4:35]};

  // Response route: X first, then Y, toward the requester
  always_comb begin
    w_port = 3'd4;
    if (r_src[3:2] > LX)      w_port = 3'd1;
    else if (r_src[3:2] < LX) w_port = 3'd0;
    else if (r_src[1:0] > LY) w_port = 3'd3;
    else if (r_src[1:0] < LY) w_port = 3'd2;
  end
  assign w_rsp_hdr = {w_port, r_src, LX, LY, 1'b1, 1'b0, r_cmd};
  assign w_cr_ok   = (r_credit != '0);

`ifdef NI_SLV_TIMEOUT_EN
  localparam int TW = $clog2(WB_TIMEOUT + 1);
  logic [TW-1:0] r_tmo;
  always_ff @(posedge clk) begin
    if (rst || r_state != S_WB) r_tmo <= '0;
    else                        r_tmo <= r_tmo + 1'b1;
  end
  assign w_tmo = (r_state == S_WB) && !wbm_ack_i && (r_tmo == TW'(WB_TIMEOUT - 1));
`else
  localparam int unused_tmo = WB_TIMEOUT;
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_state_n = r_state;
    w_pop     = 1'b0;
    w_send    = 1'b0;
    w_oh      = 1'b0;
    w_ot      = 1'b0;
    w_op      = r_rdat;
    case (r_state)
      S_IDLE: if (!w_empty) begin
        w_pop = 1'b1;
        if (w_f_head) begin
          if (!w_hit)            w_state_n = w_f_tail ? S_IDLE : S_DROP;
          else if (w_f_pay[18])  w_state_n = S_GET_DATA;
          else                   w_state_n = S_WB;
        end
      end
      S_DROP: if (!w_empty) begin
        w_pop = 1'b1;
        if (w_f_tail) w_state_n = S_IDLE;
      end
      S_GET_DATA: if (!w_empty) begin
        w_pop     = 1'b1;
        w_state_n = S_WB;
      end
      S_WB: if (wbm_ack_i || w_tmo) w_state_n = S_RSP_HEAD;
      S_RSP_HEAD: if (w_cr_ok) begin
        w_send    = 1'b1;
        w_oh      = 1'b1;
        w_ot      = r_cmd[18];
        w_op      = w_rsp_hdr;
        w_state_n = r_cmd[18] ? S_IDLE : S_RSP_DATA;
      end
      S_RSP_DATA: if (w_cr_ok) begin
        w_send    = 1'b1;
        w_ot      = 1'b1;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_cmd   <= '0;
      r_wdat  <= '0;
      r_rdat  <= '0;
      r_last  <= '0;
      r_fc0   <= 1'b0;
      r_fc1   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (r_state == S_IDLE && !w_empty && w_f_head) begin
        r_src <= w_f_pay[24:21];
        r_cmd <= w_f_pay[18:0];
      end
      if (r_state == S_GET_DATA && !w_empty) r_wdat <= w_f_pay;
      if (r_state == S_WB && wbm_ack_i) r_rdat <= wbm_dat_i;
      else if (w_tmo)                   r_rdat <= 32'hDEAD_BEEF;
      if (w_send) r_last <= {1'b1, w_oh, w_ot, w_op};
      r_fc0 <= w_pop;
      r_fc1 <= channel_in[0] & channel_in[1];
    end
  end

  // VC1 credits saturate at the router buffer depth; return+send in one cycle cancel
  always_ff @(posedge clk) begin
    if (rst) r_credit <= CRW'(TX_CREDITS);
    else if (flow_ctrl_in[1] && !w_send) begin
      if (r_credit != CRW'(TX_CREDITS)) r_credit <= r_credit + 1'b1;
    end else if (w_send && !flow_ctrl_in[1]) r_credit <= r_credit - 1'b1;
  end

  assign channel_out   = w_send ? {1'b1, 1'b1, w_oh, w_ot, w_op} : {1'b0, r_last};
  assign flow_ctrl_out = {r_fc0, r_fc1};
  assign wbm_cyc_o     = (r_state == S_WB);
  assign wbm_stb_o     = (r_state == S_WB);
  assign wbm_we_o      = r_cmd[18];
  assign wbm_sel_o     = r_cmd[17:14];
  assign wbm_adr_o     = {18'b0, r_cmd[13:0]};
  assign wbm_dat_o     = r_wdat;
  assign w_unused      = ^{flow_ctrl_in[0], r_ovf};
endmodule

// File: tb/tb_ni_slave_core.sv
// Directed bench for ni_slave_core at node (1,1): reads, writes, credit stalls, drops, back-to-back traffic.
`define CHK(tag, o, e) chk(tag, 64'(o), 64'(e))
module tb_ni_slave_core;
  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:35] channel_in, channel_out;
  logic [0:1]  flow_ctrl_out, flow_ctrl_in;
  logic        cyc, stb, we, ack;
  logic [31:0] adr, wdat, rdat;
  logic [3:0]  sel;
  logic        fc_man, auto_en, slv_en, slv_mode;
  logic        fc_auto = 1'b0;
  logic [31:0] slv_rdata;

  int total = 0, bad = 0, cyc_n = 0;
  int fc0_n = 0, fc1_n = 0, wb_n = 0, wb_hi = 0, cyc_rise = 0, ack_cyc = 0;
  logic        prev_cyc = 1'b0;
  logic [35:0] rsp_q[$];
  int          rsp_cyc[$];
  logic        wb_we;
  logic [31:0] wb_adr, wb_dat;
  logic [3:0]  wb_sel;

  assign flow_ctrl_in = {1'b0, fc_man | fc_auto};
  always #5 clk = ~clk;

  ni_slave_core #(.MY_X(1), .MY_Y(1), .RX_DEPTH(3), .TX_CREDITS(3), .WB_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .channel_in(channel_in), .flow_ctrl_out(flow_ctrl_out),
    .channel_out(channel_out), .flow_ctrl_in(flow_ctrl_in),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr), .wbm_sel_o(sel),
    .wbm_dat_o(wdat), .wbm_dat_i(rdat), .wbm_ack_i(ack)
  );

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Router-side credit return: one pulse per observed response flit
  always @(negedge clk) fc_auto <= auto_en & channel_out[0];

  // Peripheral: ack one cycle after the strobe is seen
  initial begin
    ack = 1'b0; rdat = '0;
    forever begin
      @(posedge clk); #1;
      if (cyc && stb && !ack && slv_en) begin
        ack  = 1'b1;
        rdat = slv_mode ? {16'hA5A5, adr[15:0]} : slv_rdata;
      end else ack = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (channel_out[0]) begin
      rsp_q.push_back(channel_out); rsp_cyc.push_back(cyc_n);
      total++;
      if (channel_out[1] !== 1'b1) begin
        bad++;
        $error("FAIL rsp_vc: vc bit=%0b expected 1", channel_out[1]);
      end
    end
    if (stb !== cyc) begin
      total++; bad++;
      $error("FAIL wb_stb: stb=%0b cyc=%0b", stb, cyc);
    end
    if (flow_ctrl_out[0]) fc0_n++;
    if (flow_ctrl_out[1]) fc1_n++;
    if (cyc && !prev_cyc) begin wb_n++; cyc_rise = cyc_n; end
    if (cyc) wb_hi++;
    if (cyc && stb) begin wb_we = we; wb_adr = adr; wb_sel = sel; wb_dat = wdat; end
    if (ack) ack_cyc = cyc_n;
    prev_cyc = cyc;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vc, input logic h, input logic t, input logic [31:0] p);
    @(negedge clk); channel_in = {1'b1, vc, h, t, p};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(negedge clk); channel_in[0] = 1'b0; end
  endtask

  task automatic cpulse(output int pc);
    @(negedge clk); fc_man = 1'b1; pc = cyc_n;
    @(negedge clk); fc_man = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input string tag);
    int k = 0;
    while (rsp_q.size() < n && k < 300) begin @(negedge clk); k++; end
    `CHK({tag, "_arrive"}, rsp_q.size() >= n, 1'b1);
  endtask

  function automatic logic [31:0] req(input logic [1:0] sx, input logic [1:0] sy, input logic w,
                                      input logic [13:0] a);
    return {3'd4, 2'd1, 2'd1, sx, sy, 1'b1, 1'b1, w, 4'hF, a};
  endfunction

  function automatic logic [35:0] rsp_h(input logic [2:0] port, input logic [1:0] sx, input logic [1:0] sy,
                                        input logic w, input logic [13:0] a);
    return {1'b1, 1'b1, 1'b1, w, port, sx, sy, 2'd1, 2'd1, 1'b1, 1'b0, w, 4'hF, a};
  endfunction

  function automatic logic [35:0] rsp_d(input logic [31:0] d);
    return {4'b1101, d};
  endfunction

  initial begin
    int t0, b, p, base0, base1, basew;
    logic [31:0] hd;
    rst = 1'b1; channel_in = '0; fc_man = 1'b0; auto_en = 1'b0;
    slv_en = 1'b1; slv_mode = 1'b0; slv_rdata = '0;
    repeat (3) @(negedge clk);
    `CHK("rst_chan", channel_out, 36'h0);
    `CHK("rst_fc", flow_ctrl_out, 2'b00);
    `CHK("rst_wb", {cyc, stb, we, sel}, 7'h0);
    `CHK("rst_adr", adr, 32'h0);
    rst = 1'b0;

    // Read from src (0,0): response goes west
    slv_rdata = 32'h1234_5678; b = rsp_q.size(); base0 = fc0_n;
    drive(1'b0, 1'b1, 1'b1, req(2'd0, 2'd0, 1'b0, 14'h0010)); t0 = cyc_n; idle(1);
    wait_rsp(b + 2, "rd");
    `CHK("rd_head", rsp_q[b], rsp_h(3'd0, 2'd0, 2'd0, 1'b0, 14'h0010));
    `CHK("rd_data", rsp_q[b+1], rsp_d(32'h1234_5678));
    `CHK("rd_adr", wb_adr, 32'h10);
    `CHK("rd_we", wb_we, 1'b0);
    `CHK("rd_cyc_lat", cyc_rise - t0, 2);
    `CHK("rd_head_lat", rsp_cyc[b] - ack_cyc, 1);
    `CHK("rd_data_lat", rsp_cyc[b+1] - ack_cyc, 2);
    idle(2);
    `CHK("rd_credits", fc0_n - base0, 1);

    // Write: two-flit request, single-flit response (uses the last VC1 credit)
    b = rsp_q.size(); base0 = fc0_n;
    drive(1'b0, 1'b1, 1'b0, req(2'd0, 2'd0, 1'b1, 14'h0004));
    drive(1'b0, 1'b0, 1'b1, 32'hCAFE_F00D); idle(1);
    wait_rsp(b + 1, "wr"); idle(4);
    `CHK("wr_rsp", rsp_q[b], rsp_h(3'd0, 2'd0, 2'd0, 1'b1, 14'h0004));
    `CHK("wr_only1", rsp_q.size(), b + 1);
    `CHK("wr_we", wb_we, 1'b1);
    `CHK("wr_dat", wb_dat, 32'hCAFE_F00D);
    `CHK("wr_adr", wb_adr, 32'h4);
    `CHK("wr_sel", wb_sel, 4'hF);
    `CHK("wr_credits", fc0_n - base0, 2);

    // No VC1 credit: response held until the router returns credits one by one
    b = rsp_q.size(); basew = wb_n; slv_rdata = 32'h0BAD_F00D;
    drive(1'b0, 1'b1, 1'b1, req(2'd0, 2'd0, 1'b0, 14'h0030)); idle(12);
    `CHK("cr0_hold", rsp_q.size(), b);
    `CHK("cr0_wb", wb_n - basew, 1);
    cpulse(p); idle(2);
    `CHK("cr1_head", rsp_q.size(), b + 1);
    `CHK("cr1_lat", rsp_cyc[b], p + 1);
    `CHK("cr1_hdr", rsp_q[b], rsp_h(3'd0, 2'd0, 2'd0, 1'b0, 14'h0030));
    idle(4);
    `CHK("cr1_hold", rsp_q.size(), b + 1);
    cpulse(p); idle(2);
    `CHK("cr2_data", rsp_q[b+1], rsp_d(32'h0BAD_F00D));

    // Four returns on zero credit saturate at three
    slv_mode = 1'b1;
    repeat (4) cpulse(p);
    b = rsp_q.size();
    drive(1'b0, 1'b1, 1'b1, req(2'd0, 2'd0, 1'b0, 14'h0100));
    drive(1'b0, 1'b1, 1'b1, req(2'd0, 2'd0, 1'b0, 14'h0101)); idle(30);
    `CHK("sat_3", rsp_q.size(), b + 3);
    cpulse(p); idle(3);
    `CHK("sat_4", rsp_q.size(), b + 4);
    `CHK("sat_last", rsp_q[b+3], rsp_d(32'hA5A5_0101));

    // VC1 flit discarded; packet for another node drained silently
    repeat (3) cpulse(p);
    b = rsp_q.size(); base0 = fc0_n; base1 = fc1_n; basew = wb_n;
    drive(1'b1, 1'b1, 1'b1, 32'h0); idle(3);
    `CHK("vc1_fc1", fc1_n - base1, 1);
    `CHK("vc1_fc0", fc0_n - base0, 0);
    hd = {3'd1, 2'd2, 2'd1, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 4'hF, 14'h0008};
    drive(1'b0, 1'b1, 1'b0, hd);
    drive(1'b0, 1'b0, 1'b1, 32'h1111_2222); idle(10);
    `CHK("drop_fc0", fc0_n - base0, 2);
    `CHK("drop_wb", wb_n - basew, 0);
    `CHK("drop_rsp", rsp_q.size(), b);

    // Three back-to-back reads from different sources: E, N and S routes
    auto_en = 1'b1; b = rsp_q.size(); base0 = fc0_n;
    drive(1'b0, 1'b1, 1'b1, req(2'd3, 2'd1, 1'b0, 14'h0040));
    drive(1'b0, 1'b1, 1'b1, req(2'd1, 2'd2, 1'b0, 14'h0041));
    drive(1'b0, 1'b1, 1'b1, req(2'd1, 2'd0, 1'b0, 14'h0042)); idle(1);
    wait_rsp(b + 6, "b2b");
    `CHK("b2b_h0", rsp_q[b],   rsp_h(3'd1, 2'd3, 2'd1, 1'b0, 14'h0040));
    `CHK("b2b_d0", rsp_q[b+1], rsp_d(32'hA5A5_0040));
    `CHK("b2b_h1", rsp_q[b+2], rsp_h(3'd3, 2'd1, 2'd2, 1'b0, 14'h0041));
    `CHK("b2b_d1", rsp_q[b+3], rsp_d(32'hA5A5_0041));
    `CHK("b2b_h2", rsp_q[b+4], rsp_h(3'd2, 2'd1, 2'd0, 1'b0, 14'h0042));
    `CHK("b2b_d2", rsp_q[b+5], rsp_d(32'hA5A5_0042));
    idle(2);
    `CHK("b2b_credits", fc0_n - base0, 3);

`ifdef NI_SLV_TIMEOUT_EN
    begin
      int baseh;
      slv_en = 1'b0; b = rsp_q.size(); baseh = wb_hi;
      drive(1'b0, 1'b1, 1'b1, req(2'd0, 2'd0, 1'b0, 14'h0050)); idle(1);
      wait_rsp(b + 2, "tmo");
      `CHK("tmo_cyc_len", wb_hi - baseh, TMO);
      `CHK("tmo_head", rsp_q[b], rsp_h(3'd0, 2'd0, 2'd0, 1'b0, 14'h0050));
      `CHK("tmo_data", rsp_q[b+1], rsp_d(32'hDEAD_BEEF));
    end
`endif

    // Reset while a Wishbone cycle is stalled
    slv_en = 1'b0;
    drive(1'b0, 1'b1, 1'b1, req(2'd0, 2'd0, 1'b0, 14'h0060)); idle(4);
    `CHK("abort_cyc_hi", cyc, 1'b1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    `CHK("abort_cyc_lo", cyc, 1'b0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
